// File: rtl/fifo_stream_pkg.sv
// rtl/fifo_stream_pkg.sv - shared constants and types for the FIFO read-side stream adapter
package fifo_stream_pkg;

   localparam int DEFAULT_DATA_WIDTH = 32;
   localparam int SKID_DEPTH         = 2;

   typedef logic [1:0] occ_t;

endpackage

// File: rtl/stream_skid_buf.sv
// rtl/stream_skid_buf.sv - two-entry skid buffer with registered head, push/pop and occupancy
module stream_skid_buf
   import fifo_stream_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_push,
   input  logic [DATA_WIDTH-1:0] i_push_data,
   input  logic                  i_pop,
   output logic [DATA_WIDTH-1:0] o_head,
   output occ_t                  o_occ
);

   logic [DATA_WIDTH-1:0] r_head;
   logic [DATA_WIDTH-1:0] r_tail;
   occ_t                  r_occ;

   // Push while full without a pop is excluded by the issue logic upstream.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_occ  <= 2'd0;
         r_head <= '0;
         r_tail <= '0;
      end else begin
         case (r_occ)
            2'd0: begin
               if (i_push) begin
                  r_head <= i_push_data;
                  r_occ  <= 2'd1;
               end
            end
            2'd1: begin
               case ({i_push, i_pop})
                  2'b11: r_head <= i_push_data;
                  2'b10: begin
                     r_tail <= i_push_data;
                     r_occ  <= 2'd2;
                  end
                  2'b01: r_occ <= 2'd0;
                  default: ;
               endcase
            end
            2'd2: begin
               if (i_pop) begin
                  r_head <= r_tail;
                  if (i_push) begin
                     r_tail <= i_push_data;
                  end else begin
                     r_occ <= 2'd1;
                  end
               end
            end
            default: r_occ <= 2'd0;
         endcase
      end
   end

   assign o_head = r_head;
   assign o_occ  = r_occ;

endmodule

// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - FIFO read port to valid/ready stream; stats ports with FIFO_RD_STREAM_STATS_EN
module fifo_rd_stream
   import fifo_stream_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic                  r_en,
   input  logic [DATA_WIDTH-1:0] data_out,
   input  logic                  empty,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data
`ifdef FIFO_RD_STREAM_STATS_EN
   ,
   output logic [CNT_WIDTH-1:0]  xfer_cnt,
   output logic [CNT_WIDTH-1:0]  stall_cnt
`endif
);

   if (DATA_WIDTH < 1 || CNT_WIDTH < 1) begin : g_param_check
      $error("fifo_rd_stream: DATA_WIDTH and CNT_WIDTH must be positive");
   end

   logic       r_inflight;
   occ_t       w_occ;
   logic       w_pop;
   logic [2:0] w_level;

   assign m_valid = (w_occ != 2'd0);
   assign w_pop   = m_valid && m_ready;

   // Words owned after this cycle's pop; m_ready and empty reach r_en combinationally.
   assign w_level = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
   assign r_en    = rst_n && !empty && (w_level < 3'(SKID_DEPTH));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_inflight <= 1'b0;
      end else begin
         r_inflight <= r_en;
      end
   end

   stream_skid_buf #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_skid (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_push      (r_inflight),
      .i_push_data (data_out),
      .i_pop       (w_pop),
      .o_head      (m_data),
      .o_occ       (w_occ)
   );

`ifdef FIFO_RD_STREAM_STATS_EN
   logic [CNT_WIDTH-1:0] r_xfer_cnt;
   logic [CNT_WIDTH-1:0] r_stall_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_xfer_cnt  <= '0;
         r_stall_cnt <= '0;
      end else begin
         if (w_pop && (r_xfer_cnt != '1)) begin
            r_xfer_cnt <= r_xfer_cnt + CNT_WIDTH'(1);
         end
         if (m_valid && !m_ready && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
         end
      end
   end

   assign xfer_cnt  = r_xfer_cnt;
   assign stall_cnt = r_stall_cnt;
`endif

endmodule
